candidate_generator: RTL and testbench

- Brute-force plaintext source. Sits directly upstream of the MD5 encrypter/controller path and replaces the free-running guess source with a handshaked one.
- Enumerates strings over a fixed contiguous character set as a variable-length odometer. Supports strided partitioning (start offset plus increment) so several cores can share one keyspace.
- Presents each candidate as a 128-bit MSB-first word with its bit width, using a valid/ready handshake.

---
 rtl/candidate_generator.sv | 220 ++++++++++++++++++++++
 tb/tb_candidate_generator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/candidate_generator.sv
// -----------------------------------------------------------------------------
// candidate_generator
//
// Handshaked brute-force plaintext source. It counts through every string over
// a contiguous character set as a variable-length odometer. The least
// significant digit is the last character. Digit 0 advances by a per-run
// stride, so several cores can share one keyspace by using different start
// offsets with the same stride.
//
// Ports
//   clock            : system clock, rising edge
//   reset            : asynchronous, active-low reset
//   start            : begin a new enumeration (sampled in IDLE or DONE)
//   stop             : abort the enumeration, return to IDLE
//   startingPosition : initial value of digit 0 (reduced mod CHARSET_SIZE)
//   increment        : stride added to digit 0 per candidate (0 acts as 1)
//   guess            : candidate, first character in [127:120], unused bytes 0
//   guess_width      : candidate length in bits (8 * length)
//   guess_valid      : candidate valid
//   guess_ready      : consumer accepts the candidate
//   busy             : high while enumerating
//   done             : keyspace exhausted (level)
//   count            : number of accepted candidates (saturating)
// -----------------------------------------------------------------------------
module candidate_generator #(
    parameter int          MAX_LEN      = 16,
    parameter int          CHARSET_SIZE = 26,
    parameter logic [7:0]  CHAR_BASE    = 8'h61
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [7:0]   startingPosition,
    input  logic [2:0]   increment,
    output logic [127:0] guess,
    output logic [7:0]   guess_width,
    output logic         guess_valid,
    input  logic         guess_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  count
);

    localparam int         LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [8:0] CS9       = 9'(CHARSET_SIZE);
    localparam logic [7:0] TOP_DIGIT = 8'(CHARSET_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [7:0]         r_digit [MAX_LEN];
    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_stride;
    logic [127:0]       r_guess;
    logic [7:0]         r_guess_width;
    logic               r_guess_valid;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_count;

    // Build the MSB-first character string: byte k holds digit[len-1-k].
    function automatic logic [127:0] pack_guess(
        input logic [7:0]       d [MAX_LEN],
        input logic [LEN_W-1:0] len
    );
        logic [127:0] g;
        g = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                if ((k < int'(len)) && (j == int'(len) - 1 - k)) begin
                    g[127 - 8*k -: 8] = CHAR_BASE + d[j];
                end
            end
        end
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Odometer advance (combinational)
    // ------------------------------------------------------------------
    logic [8:0]         w_sum0;
    logic               w_wrap0;
    logic [7:0]         w_next_digit [MAX_LEN];
    logic [MAX_LEN:1]   w_carry;      // w_carry[i] = carry into digit i
    logic [MAX_LEN-1:0] w_top_hit;
    logic               w_top_carry;
    logic               w_at_max;
    logic               w_exhaust;
    logic [LEN_W-1:0]   w_next_len;
    logic [127:0]       w_next_guess;
    logic [7:0]         w_next_width;
    logic               w_handshake;
    logic [7:0]         w_start_digit;
    logic [2:0]         w_start_stride;
    logic [31:0]        w_count_inc;

    // Digit 0 is widened to 9 bits so digit + stride cannot overflow before
    // the wrap compare, even for a charset close to 255 entries.
    assign w_sum0          = {1'b0, r_digit[0]} + {6'd0, r_stride};
    assign w_wrap0         = (w_sum0 >= CS9);
    assign w_next_digit[0] = w_wrap0 ? 8'(w_sum0 - CS9) : w_sum0[7:0];
    assign w_carry[1]      = w_wrap0;

    // Higher digits ripple a single carry; digits at or above the current
    // length stay zero so they are ready to become the new top digit.
    generate
        for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_digit
            logic w_active;
            assign w_active = (LEN_W'(gi) < r_len);
            assign w_next_digit[gi] = (w_active && w_carry[gi])
                                    ? ((r_digit[gi] == TOP_DIGIT) ? 8'd0 : r_digit[gi] + 8'd1)
                                    : r_digit[gi];
            assign w_carry[gi+1] = w_active && w_carry[gi] && (r_digit[gi] == TOP_DIGIT);
        end

        // Carry out of the most significant active digit (digit len-1).
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_top
            assign w_top_hit[gi] = (r_len == LEN_W'(gi + 1)) && w_carry[gi+1];
        end
    endgenerate

    assign w_top_carry  = |w_top_hit;
    assign w_at_max     = (r_len == LEN_W'(MAX_LEN));
    assign w_exhaust    = w_top_carry && w_at_max;
    assign w_next_len   = (w_top_carry && !w_at_max) ? r_len + LEN_W'(1) : r_len;
    assign w_next_guess = pack_guess(w_next_digit, w_next_len);
    assign w_next_width = 8'(w_next_len) << 3;

    assign w_handshake    = r_guess_valid && guess_ready;
    assign w_start_digit  = 8'(startingPosition % CHARSET_SIZE);
    assign w_start_stride = (increment == 3'd0) ? 3'd1 : increment;
    assign w_count_inc    = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_digit[i] <= 8'd0;
            end
            r_len         <= '0;
            r_stride      <= 3'd1;
            r_guess       <= '0;
            r_guess_width <= 8'd0;
            r_guess_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_count       <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // stop beats start; in DONE a lone stop changes nothing
                    if (start && !stop) begin
                        r_state       <= S_RUN;
                        r_digit[0]    <= w_start_digit;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            r_digit[i] <= 8'd0;
                        end
                        r_len         <= LEN_W'(1);
                        r_stride      <= w_start_stride;
                        r_guess       <= {CHAR_BASE + w_start_digit, 120'd0};
                        r_guess_width <= 8'd8;
                        r_guess_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_count       <= 32'd0;
                    end
                end

                S_RUN: begin
                    if (w_handshake) begin
                        r_count <= w_count_inc;
                    end
                    if (stop) begin
                        // Abort without advancing; guess and count keep
                        // their last values for inspection.
                        r_state       <= S_IDLE;
                        r_guess_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end else if (w_handshake) begin
                        if (w_exhaust) begin
                            r_state       <= S_DONE;
                            r_guess_valid <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_LEN; i++) begin
                                r_digit[i] <= w_next_digit[i];
                            end
                            r_len         <= w_next_len;
                            r_guess       <= w_next_guess;
                            r_guess_width <= w_next_width;
                        end
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_guess_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign guess       = r_guess;
    assign guess_width = r_guess_width;
    assign guess_valid = r_guess_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign count       = r_count;

endmodule

// File: tb/tb_candidate_generator.sv
// -----------------------------------------------------------------------------
// tb_candidate_generator
//
// Two instances: unit 0 uses the default 16 x 26 lowercase keyspace, unit 1 a
// tiny 2-character, 2-digit keyspace used to reach exhaustion. Expected
// candidates come from a numeric model (candidate = value in base CHARSET with
// a length) and are queued when the stimulus decides how many it will accept;
// a separate monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_candidate_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [1:0]          start_i;
    logic [1:0]          stop_i;
    logic [1:0]          ready_i;
    logic [1:0][7:0]     sp_i;
    logic [1:0][2:0]     inc_i;
    logic [1:0][127:0]   guess_o;
    logic [1:0][7:0]     width_o;
    logic [1:0]          valid_o;
    logic [1:0]          busy_o;
    logic [1:0]          done_o;
    logic [1:0][31:0]    count_o;

    candidate_generator dut0 (
        .clock            (clk),
        .reset            (rst_n),
        .start            (start_i[0]),
        .stop             (stop_i[0]),
        .startingPosition (sp_i[0]),
        .increment        (inc_i[0]),
        .guess            (guess_o[0]),
        .guess_width      (width_o[0]),
        .guess_valid      (valid_o[0]),
        .guess_ready      (ready_i[0]),
        .busy             (busy_o[0]),
        .done             (done_o[0]),
        .count            (count_o[0])
    );

    candidate_generator #(
        .MAX_LEN      (2),
        .CHARSET_SIZE (2),
        .CHAR_BASE    (8'h61)
    ) dut1 (
        .clock            (clk),
        .reset            (rst_n),
        .start            (start_i[1]),
        .stop             (stop_i[1]),
        .startingPosition (sp_i[1]),
        .increment        (inc_i[1]),
        .guess            (guess_o[1]),
        .guess_width      (width_o[1]),
        .guess_valid      (valid_o[1]),
        .guess_ready      (ready_i[1]),
        .busy             (busy_o[1]),
        .done             (done_o[1]),
        .count            (count_o[1])
    );

    typedef struct {
        int           unit;
        logic [127:0] g;
        logic [7:0]   w;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, one set per unit
    longint       m_v   [2];
    int           m_len [2];
    int           m_s   [2];
    int           m_cs  [2];
    int           m_max [2];
    bit           m_done[2];
    longint       m_cnt [2];
    logic [127:0] m_last_g[2];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Candidate string for numeric value v with len characters, MSB first.
    function automatic logic [127:0] model_str(input longint v, input int len, input int cs);
        logic [127:0] g;
        longint       x;
        g = '0;
        x = v;
        for (int p = len - 1; p >= 0; p--) begin
            g[127 - 8*p -: 8] = 8'h61 + 8'(x % cs);
            x = x / cs;
        end
        return g;
    endfunction

    task automatic model_start(input int u, input int sp, input int inc);
        m_v[u]    = sp % m_cs[u];
        m_len[u]  = 1;
        m_s[u]    = (inc == 0) ? 1 : inc;
        m_done[u] = 0;
        m_cnt[u]  = 0;
    endtask

    // Queue the current candidate as the next expected one, then step the
    // model: value += stride, and overflowing len digits adds a digit.
    task automatic push_expected(input int u);
        exp_t   e;
        longint pw;
        e.unit = u;
        e.g    = model_str(m_v[u], m_len[u], m_cs[u]);
        e.w    = 8'(8 * m_len[u]);
        sb_q.push_back(e);
        m_last_g[u] = e.g;
        m_cnt[u]++;
        m_v[u] += m_s[u];
        pw = 1;
        for (int i = 0; i < m_len[u]; i++) pw = pw * m_cs[u];
        if (m_v[u] >= pw) begin
            m_v[u] -= pw;
            m_len[u]++;
            if (m_len[u] > m_max[u]) m_done[u] = 1;
        end
    endtask

    // Monitor: compare every handshake against the scoreboard head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1) begin
            for (int u = 0; u < 2; u++) begin
                if (valid_o[u] && ready_i[u]) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: unit %0d presented %h with nothing expected", u, guess_o[u]);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_unit", 128'(u), 128'(e.unit));
                        check("sb_guess", guess_o[u], e.g);
                        check("sb_width", 128'(width_o[u]), 128'(e.w));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int u, input int sp, input int inc);
        sp_i[u]    = 8'(sp);
        inc_i[u]   = 3'(inc);
        stop_i[u]  = 1'b0;
        start_i[u] = 1'b1;
        tick();
        start_i[u] = 1'b0;
        // later changes must be ignored until the next start
        sp_i[u]    = 8'($urandom);
        inc_i[u]   = 3'($urandom);
        model_start(u, sp, inc);
    endtask

    // Accept exactly n candidates, optionally with random backpressure.
    task automatic drive_accept(input int u, input int n, input bit bp);
        int acc;
        int cyc;
        for (int i = 0; i < n; i++) push_expected(u);
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 2000) begin
            ready_i[u] = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (valid_o[u] && ready_i[u]) acc++;
            tick();
            cyc++;
        end
        ready_i[u] = 1'b0;
        n_checks++;
        if (acc < n) begin
            n_fail++;
            $display("FAIL accept_timeout: unit %0d accepted %0d of %0d", u, acc, n);
            sb_q.delete();
        end
    endtask

    task automatic stop_run(input int u);
        ready_i[u] = 1'b0;
        stop_i[u]  = 1'b1;
        tick();
        stop_i[u]  = 1'b0;
    endtask

    task automatic check_status(input string tag, input int u, input logic v, input logic b,
                                input logic d, input logic [31:0] c);
        check({tag, "_valid"}, 128'(valid_o[u]), 128'(v));
        check({tag, "_busy"},  128'(busy_o[u]),  128'(b));
        check({tag, "_done"},  128'(done_o[u]),  128'(d));
        check({tag, "_count"}, 128'(count_o[u]), 128'(c));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        m_cs[0] = 26; m_max[0] = 16;
        m_cs[1] = 2;  m_max[1] = 2;
        rst_n   = 1'b0;
        start_i = '0;
        stop_i  = '0;
        ready_i = '0;
        sp_i    = '0;
        inc_i   = '0;
        repeat (2) @(posedge clk);
        #3;
        for (int u = 0; u < 2; u++) begin
            check_status("reset", u, 1'b0, 1'b0, 1'b0, 32'd0);
            check("reset_guess", guess_o[u], 128'd0);
            check("reset_width", 128'(width_o[u]), 128'd0);
        end
        rst_n = 1'b1;
        tick();

        // 1: plain a..z then aa
        do_start(0, 0, 1);
        check("t1_first", guess_o[0], {8'h61, 120'd0});
        drive_accept(0, 27, 1'b0);
        check_status("t1", 0, 1'b1, 1'b1, 1'b0, 32'd27);
        check("t1_next_guess", guess_o[0], {16'h6162, 112'd0});
        check("t1_next_width", 128'(width_o[0]), 128'd16);
        stop_run(0);
        check_status("t1_stop", 0, 1'b0, 1'b0, 1'b0, 32'd27);

        // 2: offset 2, stride 3
        do_start(0, 2, 3);
        check("t2_first", guess_o[0], {8'h63, 120'd0});
        drive_accept(0, 12, 1'b1);
        check_status("t2", 0, 1'b1, 1'b1, 1'b0, 32'(m_cnt[0]));
        stop_run(0);

        // 3: backpressure hold, then resume
        do_start(0, 5, 2);
        drive_accept(0, 10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_guess", guess_o[0], model_str(m_v[0], m_len[0], 26));
            check("t3_hold_width", 128'(width_o[0]), 128'(8 * m_len[0]));
            check_status("t3_hold", 0, 1'b1, 1'b1, 1'b0, 32'd10);
            tick();
        end
        drive_accept(0, 40, 1'b1);
        check_status("t3_end", 0, 1'b1, 1'b1, 1'b0, 32'd50);
        stop_run(0);

        // 4: exhaustion of the tiny keyspace, then restart
        do_start(1, 0, 1);
        drive_accept(1, 6, 1'b0);
        check("t4_model_done", 128'(done_o[1]), 128'(m_done[1]));
        check_status("t4_done", 1, 1'b0, 1'b0, 1'b1, 32'd6);
        stop_run(1);
        check_status("t4_stop_in_done", 1, 1'b0, 1'b0, 1'b1, 32'd6);
        do_start(1, 0, 1);
        check_status("t4_restart", 1, 1'b1, 1'b1, 1'b0, 32'd0);
        check("t4_restart_guess", guess_o[1], {8'h61, 120'd0});
        drive_accept(1, 2, 1'b0);
        stop_run(1);

        // 5: stop coincident with the handshake on "k"
        do_start(0, 0, 1);
        drive_accept(0, 10, 1'b1);
        push_expected(0);
        ready_i[0] = 1'b1;
        stop_i[0]  = 1'b1;
        tick();
        stop_i[0]  = 1'b0;
        ready_i[0] = 1'b0;
        check_status("t5_stop", 0, 1'b0, 1'b0, 1'b0, 32'd11);
        check("t5_hold_guess", guess_o[0], m_last_g[0]);
        check("t5_k", guess_o[0], {8'h6b, 120'd0});
        do_start(0, 248, 1);
        check("t5_start_mod", guess_o[0], {8'h6f, 120'd0});
        drive_accept(0, 3, 1'b1);
        stop_run(0);
        start_i[0] = 1'b1;
        stop_i[0]  = 1'b1;
        tick();
        start_i[0] = 1'b0;
        stop_i[0]  = 1'b0;
        check_status("t5_start_stop", 0, 1'b0, 1'b0, 1'b0, 32'd3);
        tick();
        check_status("t5_still_idle", 0, 1'b0, 1'b0, 1'b0, 32'd3);

        // 6: asynchronous reset between edges
        do_start(0, 7, 1);
        drive_accept(0, 4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_status("t6_reset", 0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("t6_reset_guess", guess_o[0], 128'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_status("t6_after", 0, 1'b0, 1'b0, 1'b0, 32'd0);
        end

        check("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
